// File: rtl/stack_ctrl.sv
// Stack engine for PUSH/POP/CALL/RET on a full-descending word stack.
// It checks for faults when a command is accepted, runs one data-memory access, then writes back SP/LR/PC.
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP    = 32'h0000_1000,
    parameter logic [31:0] STACK_BOTTOM = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [31:0] sp_in,
    input  logic [31:0] lr_in,
    input  logic [31:0] pc_in,
    output logic        wr_sp,
    output logic        wr_lr,
    output logic        wr_pc,
    output logic [31:0] wr_sp_data,
    output logic [31:0] wr_lr_data,
    output logic [31:0] wr_pc_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  err_code
);
    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] data_q, sp_q, lr_q, pc_q;
    logic        is_down;
    logic [1:0]  fault_code;

    assign cmd_ready = (state == IDLE);
    assign is_down   = (cmd_op == OP_PUSH) || (cmd_op == OP_CALL);

    always_comb begin
        fault_code = 2'b00;
        if (sp_in[1:0] != 2'b00)
            fault_code = 2'b11;
        else if (is_down && (sp_in < STACK_BOTTOM + 32'd4))
            fault_code = 2'b01;
        else if (!is_down && (sp_in >= STACK_TOP))
            fault_code = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            data_q     <= '0;
            sp_q       <= '0;
            lr_q       <= '0;
            pc_q       <= '0;
            wr_sp      <= 1'b0;
            wr_lr      <= 1'b0;
            wr_pc      <= 1'b0;
            wr_sp_data <= '0;
            wr_lr_data <= '0;
            wr_pc_data <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        sp_q   <= sp_in;
                        lr_q   <= lr_in;
                        pc_q   <= pc_in;
                        if (fault_code != 2'b00) begin
                            state     <= WB;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            err_code  <= fault_code;
                        end else begin
                            state    <= MEM;
                            mem_req  <= 1'b1;
                            mem_we   <= is_down;
                            mem_addr <= is_down ? sp_in - 32'd4 : sp_in;
                            if (cmd_op == OP_PUSH)
                                mem_wdata <= cmd_data;
                            else if (cmd_op == OP_CALL)
                                mem_wdata <= lr_in;
                            else
                                mem_wdata <= '0;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state     <= WB;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                        wr_sp     <= 1'b1;
                        case (op_q)
                            OP_PUSH: begin
                                wr_sp_data <= sp_q - 32'd4;
                                rsp_data   <= '0;
                            end
                            OP_POP: begin
                                wr_sp_data <= sp_q + 32'd4;
                                rsp_data   <= mem_rdata;
                            end
                            OP_CALL: begin
                                wr_sp_data <= sp_q - 32'd4;
                                wr_lr      <= 1'b1;
                                wr_lr_data <= pc_q + 32'd4;
                                wr_pc      <= 1'b1;
                                wr_pc_data <= data_q;
                                rsp_data   <= pc_q + 32'd4;
                            end
                            default: begin
                                wr_sp_data <= sp_q + 32'd4;
                                wr_pc      <= 1'b1;
                                wr_pc_data <= lr_q;
                                wr_lr      <= 1'b1;
                                wr_lr_data <= mem_rdata;
                                rsp_data   <= lr_q;
                            end
                        endcase
                    end
                end
                WB: begin
                    state      <= IDLE;
                    wr_sp      <= 1'b0;
                    wr_lr      <= 1'b0;
                    wr_pc      <= 1'b0;
                    wr_sp_data <= '0;
                    wr_lr_data <= '0;
                    wr_pc_data <= '0;
                    rsp_valid  <= 1'b0;
                    rsp_data   <= '0;
                    rsp_err    <= 1'b0;
                    err_code   <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: stimulus queues expected write-backs and a monitor checks each rsp_valid.
module tb_stack_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0, sp_in = '0, lr_in = '0, pc_in = '0;
    logic        wr_sp, wr_lr, wr_pc;
    logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  err_code;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        logic        wsp;
        logic [31:0] spd;
        logic        wlr;
        logic [31:0] lrd;
        logic        wpc;
        logic [31:0] pcd;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .sp_in(sp_in), .lr_in(lr_in), .pc_in(pc_in),
        .wr_sp(wr_sp), .wr_lr(wr_lr), .wr_pc(wr_pc),
        .wr_sp_data(wr_sp_data), .wr_lr_data(wr_lr_data), .wr_pc_data(wr_pc_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] rd, input logic err, input logic [1:0] code,
                                input logic wsp, input logic [31:0] spd,
                                input logic wlr, input logic [31:0] lrd,
                                input logic wpc, input logic [31:0] pcd);
        rsp_t r;
        r.rdata = rd; r.err = err; r.code = code;
        r.wsp = wsp; r.spd = spd; r.wlr = wlr; r.lrd = lrd; r.wpc = wpc; r.pcd = pcd;
        return r;
    endfunction

    // Monitor: every WB cycle must match the oldest queued expectation; strobes never outside WB.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data",   rsp_data,          e.rdata);
                    chk("rsp_err",    32'(rsp_err),      32'(e.err));
                    chk("err_code",   32'(err_code),     32'(e.code));
                    chk("wr_sp",      32'(wr_sp),        32'(e.wsp));
                    chk("wr_sp_data", wr_sp_data,        e.spd);
                    chk("wr_lr",      32'(wr_lr),        32'(e.wlr));
                    chk("wr_lr_data", wr_lr_data,        e.lrd);
                    chk("wr_pc",      32'(wr_pc),        32'(e.wpc));
                    chk("wr_pc_data", wr_pc_data,        e.pcd);
                end
            end else if (wr_sp || wr_lr || wr_pc) begin
                chk("strobe_outside_wb", {29'd0, wr_sp, wr_lr, wr_pc}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] sp,
                         input logic [31:0] lr, input logic [31:0] pc, input int dly,
                         input logic [31:0] rdata, input logic fault,
                         input logic [31:0] eaddr, input logic ewe, input logic [31:0] ewdata,
                         input rsp_t exp);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        exp_q.push_back(exp);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; sp_in = sp; lr_in = lr; pc_in = pc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_data = 32'hA5A5_A5A5;
        sp_in = 32'h0000_0BAD; lr_in = 32'h1111_1111; pc_in = 32'h2222_2222;
        @(negedge clk);
        if (fault) begin
            chk("fault_no_mem_req", 32'(mem_req), 32'd0);
            chk("fault_wb_t1", 32'(rsp_valid), 32'd1);
        end else begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(ewe));
            chk("mem_addr", mem_addr, eaddr);
            chk("mem_wdata", mem_wdata, ewdata);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("mem_req_hold", 32'(mem_req), 32'd1);
                chk("mem_addr_hold", mem_addr, eaddr);
                chk("mem_wdata_hold", mem_wdata, ewdata);
                chk("no_early_rsp", 32'(rsp_valid), 32'd0);
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(posedge clk);
            #1;
            mem_ack = 1'b0; mem_rdata = 32'hFFFF_0000;
            @(negedge clk);
            chk("mem_req_dropped", 32'(mem_req), 32'd0);
            chk("wb_after_ack", 32'(rsp_valid), 32'd1);
        end
        @(negedge clk);
        chk("back_to_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PUSH 0xDEADBEEF at sp 0x1000
        issue(2'b00, 32'hDEAD_BEEF, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 1'b0,
              32'h0FFC, 1'b1, 32'hDEAD_BEEF,
              mk(32'h0, 1'b0, 2'b00, 1'b1, 32'h0FFC, 1'b0, 32'h0, 1'b0, 32'h0));
        // POP at sp 0x0FFC
        issue(2'b01, 32'h0, 32'h0FFC, 32'h0, 32'h0, 0, 32'h1234_5678, 1'b0,
              32'h0FFC, 1'b0, 32'h0,
              mk(32'h1234_5678, 1'b0, 2'b00, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0));
        // CALL 0x200, pc 0x40, lr 0x80
        issue(2'b10, 32'h200, 32'h1000, 32'h80, 32'h40, 0, 32'h0, 1'b0,
              32'h0FFC, 1'b1, 32'h80,
              mk(32'h44, 1'b0, 2'b00, 1'b1, 32'h0FFC, 1'b1, 32'h44, 1'b1, 32'h200));
        // Faults
        issue(2'b01, 32'h0, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0,
              mk(32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        issue(2'b00, 32'h5, 32'h0803, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0,
              mk(32'h0, 1'b1, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        issue(2'b00, 32'h5, 32'h0800, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0,
              mk(32'h0, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        // Lowest legal PUSH: sp 0x0804 writes 0x0800
        issue(2'b00, 32'hCAFE_0001, 32'h0804, 32'h0, 32'h0, 1, 32'h0, 1'b0,
              32'h0800, 1'b1, 32'hCAFE_0001,
              mk(32'h0, 1'b0, 2'b00, 1'b1, 32'h0800, 1'b0, 32'h0, 1'b0, 32'h0));
        // RET with ack delayed 3 cycles
        issue(2'b11, 32'h0, 32'h0FFC, 32'h44, 32'h0, 3, 32'h80, 1'b0,
              32'h0FFC, 1'b0, 32'h0,
              mk(32'h44, 1'b0, 2'b00, 1'b1, 32'h1000, 1'b1, 32'h80, 1'b1, 32'h44));

        // Reset pulse while in MEM: no write-back, late ack ignored
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'h77; sp_in = 32'h1000;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_after_mem_req", 32'(mem_req), 32'd0);
        chk("rst_after_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);

        // Normal PUSH after reset still works
        issue(2'b00, 32'h0000_0ABC, 32'h0FF8, 32'h0, 32'h0, 0, 32'h0, 1'b0,
              32'h0FF4, 1'b1, 32'h0000_0ABC,
              mk(32'h0, 1'b0, 2'b00, 1'b1, 32'h0FF4, 1'b0, 32'h0, 1'b0, 32'h0));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter STACK_TOP, default 32'h0000_1000, the empty-stack SP value and the exclusive upper bound.
REQ-002 SHALL have parameter STACK_BOTTOM, default 32'h0000_0800, the lowest legal stack word address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accept; transfer when cmd_valid&&cmd_ready.
REQ-007 SHALL have port cmd_op, input, 2, opcode: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-008 SHALL have port cmd_data, input, 32, PUSH data or CALL target.
REQ-009 SHALL have ports sp_in, lr_in and pc_in, input, 32 each, current SP, LR and PC from the special register file.
REQ-010 SHALL have ports wr_sp, wr_lr and wr_pc, output, 1 each, one-cycle write strobes to the special register file.
REQ-011 SHALL have ports wr_sp_data, wr_lr_data and wr_pc_data, output, 32 each, write data qualified by the matching strobe.
REQ-012 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_rdata (input, 32) and mem_ack (input, 1), forming the data-memory port.
REQ-013 SHALL have ports rsp_valid (output, 1), rsp_data (output, 32), rsp_err (output, 1) and err_code (output, 2) for completion and result.

Function
REQ-014 SHALL implement a full-descending word stack: PUSH does SP-=4 then mem[SP]=data; POP does data=mem[SP] then SP+=4.
REQ-015 SHALL implement states IDLE, MEM and WB; cmd_ready=1 only in IDLE.
REQ-016 SHALL capture cmd_op, cmd_data, sp_in, lr_in and pc_in on accept; later changes on those inputs SHALL NOT affect the operation in flight.
REQ-017 SHALL check faults on the accept cycle, in priority misaligned (sp_in[1:0]!=0, code 11) > overflow (PUSH/CALL with sp_in < STACK_BOTTOM+4, code 01) > underflow (POP/RET with sp_in >= STACK_TOP, code 10).
REQ-018 On a fault: go IDLE->WB, issue no memory request and no register write, and in WB assert rsp_valid=1, rsp_err=1 and err_code.
REQ-019 Without a fault: go IDLE->MEM, assert mem_req from the cycle after accept, and hold mem_req, mem_we, mem_addr and mem_wdata stable until the mem_ack cycle.
REQ-020 PUSH SHALL set mem_we=1, mem_addr=sp-4, mem_wdata=data.
REQ-021 CALL SHALL set mem_we=1, mem_addr=sp-4, mem_wdata=lr.
REQ-022 POP and RET SHALL set mem_we=0, mem_addr=sp, and capture mem_rdata on mem_ack.
REQ-023 On mem_ack: drop mem_req the next cycle and go MEM->WB; mem_ack outside MEM SHALL be ignored.
REQ-024 WB SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-025 In WB, PUSH SHALL set wr_sp=1, wr_sp_data=sp-4, rsp_data=0.
REQ-026 In WB, POP SHALL set wr_sp=1, wr_sp_data=sp+4, rsp_data=popped word.
REQ-027 In WB, CALL SHALL set wr_sp=1 (sp-4), wr_lr=1 (pc+4), wr_pc=1 (captured cmd_data), rsp_data=pc+4.
REQ-028 In WB, RET SHALL set wr_sp=1 (sp+4), wr_pc=1 (captured lr), wr_lr=1 (popped word), rsp_data=captured lr.
REQ-029 All address arithmetic SHALL be 32-bit modulo 2^32; bounds checks SHALL be unsigned.
REQ-030 Write strobes and rsp_valid SHALL be high only in WB; all other outputs SHALL be 0 outside their qualifying state.
REQ-031 Minimum latency SHALL be accept at T, mem_req at T+1, mem_ack at T+1, WB at T+2, next accept at T+3; a fault SHALL give WB at T+1.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE and drive cmd_ready=1 and all other outputs to 0, asynchronously.
REQ-033 Reset during MEM or WB SHALL abort the operation with no register write; a mem_ack arriving after reset SHALL be ignored.
REQ-034 Normal operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 PUSH 0xDEADBEEF with sp_in=0x1000 and mem_ack at T+1 -> mem write to addr 0x0FFC of data 0xDEADBEEF, then WB with wr_sp_data=0x0FFC.
REQ-036 POP with sp_in=0x0FFC and mem_rdata=0x12345678 -> rsp_data=0x12345678, wr_sp_data=0x1000.
REQ-037 CALL target 0x200 with pc=0x40, lr=0x80 and sp=0x1000 -> mem[0x0FFC]=0x80, wr_lr_data=0x44, wr_pc_data=0x200, wr_sp_data=0x0FFC.
REQ-038 Faults: POP at sp=0x1000 gives err 10; PUSH at sp=0x0803 gives err 11; PUSH at sp=0x0800 gives err 01; in all three cases no mem_req, WB at T+1 and no write strobes.
REQ-039 RET with lr=0x44 and popped word 0x80, mem_ack delayed 3 cycles -> mem_req held stable throughout, wr_pc_data=0x44, wr_lr_data=0x80.
REQ-040 rst_n pulsed low while in MEM -> mem_req drops immediately, no wr_* strobe and no rsp_valid, cmd_ready=1 after release.
